// File: rtl/lcd_write_engine.sv
// lcd_write_engine
// Drives an HD44780-compatible 8-bit LCD bus. After reset it waits out the
// panel power-up time and sends the init bytes 0x38, 0x38, 0x0C, 0x01, 0x06.
// It then accepts one byte per grant from the upstream digit sequencer.
// Optional build macro: LCD_BUSY_POLL_EN. When defined, the fixed post-command
// wait is replaced by busy-flag polling (read cycles sampling lcdBus[7]).
module lcd_write_engine #(
    parameter int unsigned SETUP_CYC   = 3,
    parameter int unsigned EN_HIGH_CYC = 12,
    parameter int unsigned HOLD_CYC    = 3,
    parameter int unsigned EXEC_CYC    = 2000,
    parameter int unsigned CLEAR_CYC   = 80000,
    parameter int unsigned POWERUP_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       addrOrData,
    input  logic [7:0] inBus,
    inout  wire  [7:0] lcdBus,
    output logic       lcdReadWriteSel,
    output logic       lcdRsSelect,
    output logic       lcdEnableOut,
    output logic       errorLed,
    output logic       busLock
);

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT,
        ST_GRANT,
        ST_CAPT,
        ST_BUSY_SETUP,
        ST_BUSY_EN,
        ST_BUSY_SMP
    } state_t;

    // Reload values are duration-1; a zero duration is treated as one cycle.
    localparam logic [31:0] SETUP_LD = (SETUP_CYC   == 0) ? 32'd0 : 32'(SETUP_CYC - 1);
    localparam logic [31:0] EN_LD    = (EN_HIGH_CYC == 0) ? 32'd0 : 32'(EN_HIGH_CYC - 1);
    localparam logic [31:0] HOLD_LD  = (HOLD_CYC    == 0) ? 32'd0 : 32'(HOLD_CYC - 1);
    localparam logic [31:0] EXEC_LD  = (EXEC_CYC    == 0) ? 32'd0 : 32'(EXEC_CYC - 1);
    localparam logic [31:0] CLEAR_LD = (CLEAR_CYC   == 0) ? 32'd0 : 32'(CLEAR_CYC - 1);
    localparam logic [31:0] PWRUP_LD = (POWERUP_CYC == 0) ? 32'd0 : 32'(POWERUP_CYC - 1);
    localparam logic [2:0]  INIT_CNT = 3'd5;

    state_t      state_q, state_d, after_wait;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        rw_q, rw_d;
    logic        en_q, en_d;
    logic        drv_q, drv_d;
    logic        clr_q, clr_d;
    logic        err_q, err_d;
    logic        lock_q, lock_d;
`ifdef LCD_BUSY_POLL_EN
    logic [31:0] poll_q, poll_d;
    logic        busy_q, busy_d;
`endif

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h38;
            3'd2:    return 8'h0C;
            3'd3:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Next-state, counter and byte/flag computation; outputs follow the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rs_d       = rs_q;
        clr_d      = clr_q;
        err_d      = err_q;
        after_wait = (idx_q == INIT_CNT) ? ST_GRANT : ST_INIT;
`ifdef LCD_BUSY_POLL_EN
        poll_d     = poll_q;
        busy_d     = busy_q;
`endif
        unique case (state_q)
            ST_PWRUP: begin
                // Reset clears the counter, so power-up counts upward to its limit.
                if (cnt_q >= PWRUP_LD) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_INIT: begin
                data_d  = init_byte(idx_q);
                rs_d    = 1'b0;
                clr_d   = (idx_q == 3'd3);
                idx_d   = idx_q + 3'd1;
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_EN_HI;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_EN_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
`ifdef LCD_BUSY_POLL_EN
                    // The first three init bytes precede a usable busy flag.
                    if (idx_q <= 3'd3) begin
                        state_d = ST_WAIT;
                        cnt_d   = clr_q ? CLEAR_LD : EXEC_LD;
                    end else begin
                        state_d = ST_BUSY_SETUP;
                        cnt_d   = SETUP_LD;
                        rs_d    = 1'b0;
                        poll_d  = '0;
                    end
`else
                    state_d = ST_WAIT;
                    cnt_d   = clr_q ? CLEAR_LD : EXEC_LD;
`endif
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = after_wait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_GRANT: begin
                state_d = ST_CAPT;
                cnt_d   = '0;
            end
            ST_CAPT: begin
                rs_d   = addrOrData;
                data_d = addrOrData ? inBus : {1'b1, inBus[6:0]};
                clr_d  = 1'b0;
                if (!addrOrData && inBus[7]) begin
                    err_d = 1'b1;
                end
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
            end
`ifdef LCD_BUSY_POLL_EN
            ST_BUSY_SETUP: begin
                poll_d = poll_q + 32'd1;
                if (cnt_q == '0) begin
                    state_d = ST_BUSY_EN;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_BUSY_EN: begin
                poll_d = poll_q + 32'd1;
                if (cnt_q == '0) begin
                    busy_d  = lcdBus[7];
                    state_d = ST_BUSY_SMP;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_BUSY_SMP: begin
                poll_d = poll_q + 32'd1;
                if (cnt_q == '0) begin
                    if (!busy_q) begin
                        state_d = after_wait;
                        cnt_d   = '0;
                    end else if (poll_q >= CLEAR_LD) begin
                        err_d   = 1'b1;
                        state_d = after_wait;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_BUSY_SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
`endif
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase

        en_d   = (state_d == ST_EN_HI) || (state_d == ST_BUSY_EN);
        drv_d  = (state_d == ST_SETUP) || (state_d == ST_EN_HI) || (state_d == ST_HOLD);
        lock_d = (state_d != ST_GRANT);
`ifdef LCD_BUSY_POLL_EN
        rw_d   = (state_d == ST_BUSY_SETUP) || (state_d == ST_BUSY_EN) ||
                 (state_d == ST_BUSY_SMP);
`else
        rw_d   = 1'b0;
`endif
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PWRUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            en_q    <= 1'b0;
            drv_q   <= 1'b0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
            poll_q  <= '0;
            busy_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            en_q    <= en_d;
            drv_q   <= drv_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
`ifdef LCD_BUSY_POLL_EN
            poll_q  <= poll_d;
            busy_q  <= busy_d;
`endif
        end
    end

    assign lcdBus          = drv_q ? data_q : 8'bzzzz_zzzz;
    assign lcdReadWriteSel = rw_q;
    assign lcdRsSelect     = rs_q;
    assign lcdEnableOut    = en_q;
    assign errorLed        = err_q;
    assign busLock         = lock_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: directed bench for lcd_write_engine with small timing
// parameters. Pull-ups on lcdBus make a released bus read as 0xFF.
`timescale 1ns/1ps
module tb_lcd_write_engine;

    localparam int unsigned TB_SETUP = 3;
    localparam int unsigned TB_EN    = 12;
    localparam int unsigned TB_HOLD  = 3;
    localparam int unsigned TB_EXEC  = 5;
    localparam int unsigned TB_PWRUP = 10;
`ifdef LCD_BUSY_POLL_EN
    localparam int unsigned TB_CLEAR = 200;
`else
    localparam int unsigned TB_CLEAR = 20;
`endif

    typedef struct packed {
        logic [7:0]  data;
        logic        rs;
        logic        err;
        logic [31:0] rise;
        logic [31:0] width;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        addrOrData;
    logic [7:0]  inBus;
    wire  [7:0]  lcdBus;
    logic        lcdReadWriteSel;
    logic        lcdRsSelect;
    logic        lcdEnableOut;
    logic        errorLed;
    logic        busLock;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] cyc          = '0;
    pulse_t      pulses[$];
    logic [31:0] grants[$];
    int          rd_at_g[$];
    int          rd_count     = 0;
    int          reads_left   = 0;
    logic        busy_forever = 1'b0;
    logic        cur_busy     = 1'b0;

    logic        stim_ad [0:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0]  stim_by [0:5] = '{8'h03, 8'h35, 8'h85, 8'h41, 8'h42, 8'h43};
    logic [7:0]  init_exp[0:4] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_write_engine #(
        .SETUP_CYC   (TB_SETUP),
        .EN_HIGH_CYC (TB_EN),
        .HOLD_CYC    (TB_HOLD),
        .EXEC_CYC    (TB_EXEC),
        .CLEAR_CYC   (TB_CLEAR),
        .POWERUP_CYC (TB_PWRUP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .addrOrData      (addrOrData),
        .inBus           (inBus),
        .lcdBus          (lcdBus),
        .lcdReadWriteSel (lcdReadWriteSel),
        .lcdRsSelect     (lcdRsSelect),
        .lcdEnableOut    (lcdEnableOut),
        .errorLed        (errorLed),
        .busLock         (busLock)
    );

    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup (lcdBus[gi]);
    end

    // Busy flag answered by the bench only during read cycles.
    assign lcdBus[7] = lcdReadWriteSel ? cur_busy : 1'bz;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grants(input int n, input int budget, input string tag);
        int k = 0;
        while (grants.size() < n && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        check_eq(tag, 32'(grants.size() >= n), 32'd1);
    endtask

    // Upstream model and bus monitor, sampled on the falling edge.
    initial begin : monitor
        pulse_t      cur;
        logic        e_prev  = 1'b0;
        logic        in_wr   = 1'b0;
        int          stim_i  = 0;
        logic [31:0] junk_at = '0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (lcdEnableOut && !e_prev) begin
                if (!lcdReadWriteSel) begin
                    cur.data  = lcdBus;
                    cur.rs    = lcdRsSelect;
                    cur.err   = errorLed;
                    cur.rise  = cyc;
                    cur.width = '0;
                    in_wr     = 1'b1;
                end else begin
                    rd_count++;
                    cur_busy = busy_forever || (reads_left > 0);
                    if (reads_left > 0) reads_left--;
                end
            end
            if (lcdEnableOut && in_wr) cur.width = cur.width + 32'd1;
            if (!lcdEnableOut && in_wr) begin
                pulses.push_back(cur);
                in_wr = 1'b0;
            end
            e_prev = lcdEnableOut;
            if (!busLock) begin
                grants.push_back(cyc);
                rd_at_g.push_back(rd_count);
                busy_forever = 1'b0;
                if (stim_i < 6) begin
                    addrOrData = stim_ad[stim_i];
                    inBus      = stim_by[stim_i];
                    if (stim_i == 0) reads_left = 3;
                    if (stim_i == 1) busy_forever = 1'b1;
                    stim_i++;
                end
                junk_at = cyc + 32'd2;
            end else if (cyc == junk_at) begin
                // Garbage after the capture edge must be ignored.
                addrOrData = 1'b0;
                inBus      = 8'hFF;
            end
        end
    end

    initial begin
        int k;
        int n;
        rst        = 1'b0;
        addrOrData = 1'b0;
        inBus      = 8'h00;
        repeat (4) @(negedge clk);
        #2;
        check_eq("rst_en",   32'(lcdEnableOut),    32'd0);
        check_eq("rst_rs",   32'(lcdRsSelect),     32'd0);
        check_eq("rst_rw",   32'(lcdReadWriteSel), 32'd0);
        check_eq("rst_err",  32'(errorLed),        32'd0);
        check_eq("rst_lock", 32'(busLock),         32'd1);
        check_eq("rst_bus",  32'(lcdBus),          32'hFF);
        rst = 1'b1;

        // Power-up init sequence followed by the first grant.
        wait_grants(1, 3000, "grant0_seen");
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("init%0d_data", i), 32'(pulses[i].data), 32'(init_exp[i]));
            check_eq($sformatf("init%0d_rs", i),   32'(pulses[i].rs),   32'd0);
        end
        check_eq("init0_width", pulses[0].width, 32'd12);
`ifndef LCD_BUSY_POLL_EN
        check_eq("init_spacing",  pulses[1].rise - pulses[0].rise, 32'd24);
        check_eq("clear_spacing", pulses[4].rise - pulses[3].rise, 32'd39);
        check_eq("init_to_grant", grants[0] - pulses[4].rise,      32'd20);
`endif
        check_eq("grant_lock",   32'(busLock),         32'd0);
        check_eq("grant_bus_z",  32'(lcdBus),          32'hFF);
        check_eq("grant_rw",     32'(lcdReadWriteSel), 32'd0);
        @(negedge clk); #2;
        check_eq("grant_one_cyc", 32'(busLock), 32'd1);

        // Address 0x03 -> command 0x83.
        wait_grants(2, 3000, "grant1_seen");
        check_eq("addr_data",  32'(pulses[5].data),  32'h83);
        check_eq("addr_rs",    32'(pulses[5].rs),    32'd0);
        check_eq("addr_err",   32'(pulses[5].err),   32'd0);
        check_eq("addr_width", pulses[5].width,      32'd12);
        check_eq("capt_to_e",  pulses[5].rise - grants[0], 32'd5);
`ifdef LCD_BUSY_POLL_EN
        check_eq("busy_reads", 32'(rd_at_g[1] - rd_at_g[0]), 32'd4);
`else
        check_eq("period1",    grants[1] - grants[0], 32'd25);
`endif
        check_eq("err_after_addr", 32'(errorLed), 32'd0);

        // Character 0x35.
        wait_grants(3, 3000, "grant2_seen");
        check_eq("char_data", 32'(pulses[6].data), 32'h35);
        check_eq("char_rs",   32'(pulses[6].rs),   32'd1);
        check_eq("char_err",  32'(pulses[6].err),  32'd0);
`ifdef LCD_BUSY_POLL_EN
        check_eq("busy_timeout_err", 32'(errorLed), 32'd1);
`else
        check_eq("period2",   grants[2] - grants[1], 32'd25);
        check_eq("err_still_clear", 32'(errorLed), 32'd0);
`endif

        // Address with bit 7 set: masked write, sticky error.
        wait_grants(4, 3000, "grant3_seen");
        check_eq("bad_addr_data", 32'(pulses[7].data), 32'h85);
        check_eq("bad_addr_rs",   32'(pulses[7].rs),   32'd0);
        check_eq("bad_addr_err",  32'(pulses[7].err),  32'd1);
        wait_grants(5, 3000, "grant4_seen");
        check_eq("after_data", 32'(pulses[8].data), 32'h41);
        check_eq("after_rs",   32'(pulses[8].rs),   32'd1);
        check_eq("err_sticky", 32'(errorLed),       32'd1);

        // Reset in the middle of the next E pulse.
        k = 0;
        while (!lcdEnableOut && k < 200) begin
            @(negedge clk); #2;
            k++;
        end
        check_eq("en_before_rst", 32'(lcdEnableOut), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_en",   32'(lcdEnableOut),    32'd0);
        check_eq("midrst_lock", 32'(busLock),         32'd1);
        check_eq("midrst_bus",  32'(lcdBus),          32'hFF);
        check_eq("midrst_rw",   32'(lcdReadWriteSel), 32'd0);
        check_eq("midrst_err",  32'(errorLed),        32'd0);
        repeat (4) @(negedge clk);
        n   = pulses.size();
        rst = 1'b1;
        k   = 0;
        while (pulses.size() <= n && k < 3000) begin
            @(negedge clk); #2;
            k++;
        end
        check_eq("restart_seen", 32'(pulses.size() > n), 32'd1);
        check_eq("restart_data", 32'(pulses[n].data), 32'h38);
        check_eq("restart_rs",   32'(pulses[n].rs),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lcd_write_engine.md
# lcd_write_engine

Downstream stage of the digit-sequencing FSM: accepts one address-or-data byte per grant over the `addrOrData`/`inBus`/`busLock` handshake. Drives the HD44780-compatible 8-bit LCD bus with correctly timed RS/RW/E cycles. Runs the LCD power-up initialisation after reset. Sits between the digit sequencer and the LCD pins in `lcdControllerTop`.

## Interface
- `SETUP_CYC`, default 3: cycles RS/RW/data are stable before E rises (at least 40 ns).
- `EN_HIGH_CYC`, default 12: E high width in cycles (at least 230 ns).
- `HOLD_CYC`, default 3: cycles data/RS are held after E falls.
- `EXEC_CYC`, default 2000: post-command wait for normal commands and data (40 µs at 50 MHz).
- `CLEAR_CYC`, default 80000: post-command wait after 0x01 (1.6 ms).
- `POWERUP_CYC`, default 2000000: wait after reset release before the first command (40 ms).
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset. This is the `lcdOn` switch.
- `addrOrData`  in  1: 0 = `inBus` is a DDRAM address; 1 = `inBus` is a character code.
- `inBus`  in  8: byte from the upstream sequencer.
- `lcdBus`  inout  8: LCD data bus.
- `lcdReadWriteSel`  out  1: 0 = write, 1 = read.
- `lcdRsSelect`  out  1: 0 = command, 1 = data.
- `lcdEnableOut`  out  1: LCD E strobe.
- `errorLed`  out  1: sticky error flag.
- `busLock`  out  1: 0 = grant (upstream may load a new byte), 1 = locked.

## Operation
- All outputs are registered. The only combinational path is the tri-state of `lcdBus`, which is controlled by a registered drive-enable.
- Reset values:
  - `lcdEnableOut`, `lcdRsSelect`, `lcdReadWriteSel`, `errorLed` = 0.
  - `busLock` = 1.
  - `lcdBus` = high-Z.
  - State = PWRUP with counter cleared.
- States and transitions:
  - PWRUP: count POWERUP_CYC cycles, then go to INIT.
  - INIT: load the next init byte in order 0x38, 0x38, 0x0C, 0x01, 0x06, with RS=0. Go to SETUP.
  - SETUP: drive byte and RS, RW=0, E=0 for SETUP_CYC cycles. Go to EN_HI.
  - EN_HI: E=1 for EN_HIGH_CYC cycles. Go to HOLD.
  - HOLD: E=0, byte held for HOLD_CYC cycles. Go to WAIT.
  - WAIT: wait CLEAR_CYC cycles if the byte was command 0x01, otherwise EXEC_CYC cycles. Go to INIT if init bytes remain, else GRANT.
  - GRANT: `busLock`=0 for exactly one cycle. Go to CAPT with `busLock`=1.
  - CAPT: sample `inBus` and `addrOrData`. Go to SETUP.
- Byte formation at CAPT:
  - `addrOrData`=1: RS=1, byte = `inBus`.
  - `addrOrData`=0: RS=0, byte = 0x80 | `inBus[6:0]`.
  - `addrOrData`=0 with `inBus[7]`=1 sets `errorLed`, which stays set until reset. The write still proceeds with bit 7 masked.
- `lcdBus` is driven from SETUP entry through HOLD exit, and is high-Z otherwise.
- Counters are one shared down-counter, 21 bits wide minimum, reloaded on each state entry. A parameter value of 0 is treated as 1.

## Timing
- Upstream loads `inBus` on the edge where it sees `busLock`=0, i.e. the edge leaving GRANT. The engine samples it one edge later, in CAPT, while `busLock` is already 1. Exactly one byte is transferred per grant.
- Latency from CAPT to E rising is 1 + SETUP_CYC cycles.
- Grant-to-grant period is 2 + SETUP_CYC + EN_HIGH_CYC + HOLD_CYC + EXEC_CYC cycles. With defaults this is 2020.
- The first grant occurs after POWERUP_CYC plus 5 command cycles, one of which uses CLEAR_CYC.
- Reset asserted mid-operation:
  - Immediately: E=0, bus high-Z, `busLock`=1.
  - The in-flight byte is discarded.
  - After release, the full init sequence reruns.
- While `busLock`=1, `inBus` changes are ignored.

## Configuration
- `LCD_BUSY_POLL_EN` defined:
  - WAIT is replaced by a busy-poll loop: BUSY_SETUP → BUSY_EN → BUSY_SMP.
  - During the loop: RW=1, RS=0, bus high-Z, E pulsed with the same SETUP/EN_HIGH/HOLD timing.
  - `lcdBus[7]` is sampled on the last EN_HI cycle. The engine exits when it reads 0.
  - If busy has not cleared after CLEAR_CYC total cycles, `errorLed` is set (sticky) and the engine proceeds anyway.
  - PWRUP and the first three init bytes still use fixed waits.
- `LCD_BUSY_POLL_EN` undefined:
  - Fixed waits only.
  - `lcdReadWriteSel` is held at 0.
  - The bus is never sampled.

## Test plan
- Reset, then release with small parameters (POWERUP_CYC=10, EXEC_CYC=5, CLEAR_CYC=20) -> five E pulses carrying 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0; a 20-cycle gap after 0x01; then a one-cycle `busLock`=0.
- At grant, apply `addrOrData`=0, `inBus`=0x03 -> bus 0x83 with RS=0 and RW=0 during E; E high for exactly EN_HIGH_CYC cycles; `errorLed`=0.
- At grant, apply `addrOrData`=1, `inBus`=0x35 -> bus 0x35 with RS=1; the next grant arrives exactly 2+SETUP+EN+HOLD+EXEC cycles after the previous one.
- At grant, apply `addrOrData`=0, `inBus`=0x85 -> bus 0x85 written; `errorLed` rises and stays 1 through later valid writes until reset.
- Drop `rst` during EN_HI -> E=0, bus high-Z, `busLock`=1 in the same cycle; after release, the init sequence restarts from 0x38.
- With `LCD_BUSY_POLL_EN`, bench holds `lcdBus[7]`=1 for 3 polls then 0 -> 4 read E-pulses with RW=1 and `errorLed`=0. A repeat run holding `lcdBus[7]`=1 permanently -> `errorLed`=1 after CLEAR_CYC cycles and the next grant still issued.
